pipeline_ifid: RTL and testbench
================================

PIPELINE_IFID -- requirements
Module: pipeline_ifid

Interface
REQ-001 SHALL have port clk  input  1  single pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port instr_in  input  16  fetched instruction from instruction memory.
REQ-004 SHALL have port pc_plus2_in  input  16  PC+2 of the fetched instruction.
REQ-005 SHALL have port stall  input  1  load-use hazard from the hazard unit; hold IF/ID.
REQ-006 SHALL have port flush  input  1  taken branch resolved in ID; squash the wrong-path fetch.
REQ-007 SHALL have port instr_out  output  16  registered instruction to decode.
REQ-008 SHALL have port pc_plus2_out  output  16  registered PC+2 to decode and PCtoReg.
REQ-009 SHALL have port valid_out  output  1  1 = instr_out is a real instruction.
REQ-010 SHALL have port nop_to_IDEX  output  1  drives the nop input of the ID/EX register.
REQ-011 SHALL have port pc_wen  output  1  PC write enable.
REQ-012 SHALL have port halted  output  1  core halted; sticky until reset.
REQ-013 SHALL have port stall_cycles  output  16  stall counter, present only with IFID_STALL_CNT_EN.

Function
REQ-014 SHALL apply per-cycle priority HALTED > flush > stall > normal load.
REQ-015 Normal load SHALL register instr_in and pc_plus2_in and set valid_out=1; latency is one cycle.
REQ-016 On flush, the block SHALL set instr_out=16'h0000 and valid_out=0, keep pc_plus2_out, and ignore a simultaneous stall.
REQ-017 On stall without flush, the block SHALL hold instr_out, pc_plus2_out and valid_out.
REQ-018 nop_to_IDEX SHALL be combinational: valid_out==0 OR (stall AND NOT flush) OR state==HALTED.
REQ-019 pc_wen SHALL be combinational: state==RUN AND (flush OR NOT stall).
REQ-020 The FSM SHALL have the states RUN and HALTED.
REQ-021 The FSM SHALL move RUN->HALTED on the edge where valid_out=1, instr_out[15:12]==HALT_OP (4'hF), flush=0 and stall=0.
REQ-022 The halt instruction SHALL therefore reach ID/EX exactly once.
REQ-023 In HALTED, the block SHALL set valid_out=0, hold pc_plus2_out, and hold pc_wen=0 and halted=1.
REQ-024 In HALTED, the block SHALL ignore stall and flush.
REQ-025 The only exit from HALTED SHALL be reset.
REQ-026 If stall is held for N consecutive cycles, the block SHALL hold for exactly N cycles and resume on the first cycle stall=0, with no instruction lost or duplicated.

Reset
REQ-027 While rst=0, the block SHALL asynchronously force instr_out=16'h0000, pc_plus2_out=16'h0000, valid_out=0, state=RUN, halted=0 and stall_cycles=0.
REQ-028 While rst=0, nop_to_IDEX SHALL be 1 and pc_wen SHALL be 1.
REQ-029 Reset asserted mid-stall or in HALTED SHALL abort it; the first edge after rst rises SHALL be a normal load.

Configuration
REQ-030 With IFID_STALL_CNT_EN defined, stall_cycles SHALL increment by 1 on every edge where state==RUN, stall=1 and flush=0.
REQ-031 With IFID_STALL_CNT_EN defined, stall_cycles SHALL saturate at 16'hFFFF.
REQ-032 Without IFID_STALL_CNT_EN, the stall_cycles port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 The shared package pipeline_pkg SHALL hold NOP_INSTR (16'h0000), HALT_OP (4'hF) and the FSM state type {RUN, HALTED}.
REQ-034 The block SHALL have one sub-module, ifid_ctrl, containing the FSM, the pc_wen/nop_to_IDEX logic and the optional counter.
REQ-035 The datapath registers SHALL stay in pipeline_ifid.

Verification
REQ-036 Scenario: reset, then instr_in=16'h1234, pc_plus2_in=16'h0002 -> after one edge instr_out=16'h1234, pc_plus2_out=16'h0002, valid_out=1, nop_to_IDEX=0.
REQ-037 Scenario: stall=1 for 3 cycles with instr_in changing -> instr_out stays 16'h1234, pc_wen=0 and nop_to_IDEX=1 for 3 cycles; with IFID_STALL_CNT_EN, stall_cycles=3.
REQ-038 Scenario: flush=1 and stall=1 together -> next instr_out=16'h0000, valid_out=0, pc_wen=1 during that cycle, and stall_cycles unchanged.
REQ-039 Scenario: instr_in=16'hF000 loaded -> one cycle with valid_out=1 and nop_to_IDEX=0, then halted=1 and pc_wen=0 permanently; a later flush=1 has no effect.
REQ-040 Scenario: rst=0 pulsed asynchronously while HALTED -> halted=0 immediately without a clock edge; normal fetch resumes on the next edge.
REQ-041 Scenario: HALT in IF/ID with stall=1 for 2 cycles -> halted stays 0 until the first cycle after stall drops.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants and IF/ID control state type
package pipeline_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [3:0]  HALT_OP   = 4'hF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } ifid_state_t;

  // True when the opcode field of an instruction word is the halt opcode
  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:12] == HALT_OP;
  endfunction

endpackage

// File: rtl/ifid_ctrl.sv
// rtl/ifid_ctrl.sv - IF/ID control FSM, PC write enable, bubble select and optional stall counter (IFID_STALL_CNT_EN)
module ifid_ctrl
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_q,
  input  logic [15:0] instr_q,
  output logic        pc_wen,
  output logic        nop_to_IDEX,
  output logic        halted,
  output logic        halt_take
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  ifid_state_t state_q;
  ifid_state_t state_d;

  // State register; reset always returns the core to RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the combinational hazard outputs
  always_comb begin
    state_d     = state_q;
    halt_take   = 1'b0;
    pc_wen      = 1'b0;
    nop_to_IDEX = 1'b1;
    halted      = 1'b0;
    case (state_q)
      RUN: begin
        // A halt sitting in IF/ID commits only on a clean edge, so it
        // reaches ID/EX exactly once and never while being held or squashed
        halt_take   = valid_q && is_halt(instr_q) && !flush && !stall;
        pc_wen      = flush || !stall;
        nop_to_IDEX = !valid_q || (stall && !flush);
        if (halt_take) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        halted      = 1'b1;
        pc_wen      = 1'b0;
        nop_to_IDEX = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    // While reset is held the PC must keep loading its reset vector
    if (!rst) begin
      pc_wen      = 1'b1;
      nop_to_IDEX = 1'b1;
      halted      = 1'b0;
      halt_take   = 1'b0;
    end
  end

`ifdef IFID_STALL_CNT_EN
  // Count held cycles in RUN; a flush overrides the stall so is not counted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 16'h0000;
    end else if (state_q == RUN && stall && !flush && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'h0001;
    end
  end
`endif

endmodule

// File: rtl/pipeline_ifid.sv
// rtl/pipeline_ifid.sv - IF/ID pipeline register with stall, flush and halt handling (IFID_STALL_CNT_EN adds stall_cycles)
module pipeline_ifid
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_plus2_in,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2_out,
  output logic        valid_out,
  output logic        nop_to_IDEX,
  output logic        pc_wen,
  output logic        halted
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  logic halt_take;

  ifid_ctrl u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .valid_q      (valid_out),
    .instr_q      (instr_out),
    .pc_wen       (pc_wen),
    .nop_to_IDEX  (nop_to_IDEX),
    .halted       (halted),
    .halt_take    (halt_take)
`ifdef IFID_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // IF/ID datapath: halted > flush > stall > load; the halting edge
  // already drops valid so nothing fetched behind the halt escapes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_out    <= NOP_INSTR;
      pc_plus2_out <= 16'h0000;
      valid_out    <= 1'b0;
    end else if (halted || halt_take) begin
      valid_out <= 1'b0;
    end else if (flush) begin
      instr_out <= NOP_INSTR;
      valid_out <= 1'b0;
    end else if (!stall) begin
      instr_out    <= instr_in;
      pc_plus2_out <= pc_plus2_in;
      valid_out    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ifid.sv
// tb/tb_pipeline_ifid.sv - randomized and scenario bench for pipeline_ifid against a reference model (IFID_STALL_CNT_EN optional)
module tb_pipeline_ifid;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in;
  logic [15:0] pc_plus2_in;
  logic        stall;
  logic        flush;
  logic [15:0] instr_out;
  logic [15:0] pc_plus2_out;
  logic        valid_out;
  logic        nop_to_IDEX;
  logic        pc_wen;
  logic        halted;
`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  pipeline_ifid dut (
    .clk          (clk),
    .rst          (rst),
    .instr_in     (instr_in),
    .pc_plus2_in  (pc_plus2_in),
    .stall        (stall),
    .flush        (flush),
    .instr_out    (instr_out),
    .pc_plus2_out (pc_plus2_out),
    .valid_out    (valid_out),
    .nop_to_IDEX  (nop_to_IDEX),
    .pc_wen       (pc_wen),
    .halted       (halted)
`ifdef IFID_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what decode should currently see
  logic [15:0] m_instr;
  logic [15:0] m_pc;
  bit          m_valid;
  bit          m_halted;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_regs();
    check("instr_out", {16'h0, instr_out}, {16'h0, m_instr});
    check("pc_plus2_out", {16'h0, pc_plus2_out}, {16'h0, m_pc});
    check("valid_out", {31'h0, valid_out}, {31'h0, m_valid});
    check("halted", {31'h0, halted}, {31'h0, m_halted});
`ifdef IFID_STALL_CNT_EN
    check("stall_cycles", {16'h0, stall_cycles}, m_cnt);
`endif
  endtask

  // Asynchronous reset pulse in the middle of a clock high phase
  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    m_instr = 16'h0; m_pc = 16'h0; m_valid = 0; m_halted = 0; m_cnt = 0;
    check_regs();
    check("rst_pc_wen", {31'h0, pc_wen}, 32'h1);
    check("rst_nop", {31'h0, nop_to_IDEX}, 32'h1);
    #1 rst = 1'b1;
  endtask

  // One pipeline cycle: drive, check combinational outputs, clock, check state
  task automatic step(input logic [15:0] i, input logic [15:0] p, input bit s, input bit f);
    bit exp_nop, exp_wen;
    @(negedge clk);
    instr_in = i; pc_plus2_in = p; stall = s; flush = f;
    #1;
    exp_nop = !m_valid || (s && !f) || m_halted;
    exp_wen = !m_halted && (f || !s);
    check("nop_to_IDEX", {31'h0, nop_to_IDEX}, {31'h0, exp_nop});
    check("pc_wen", {31'h0, pc_wen}, {31'h0, exp_wen});
    @(posedge clk);
    if (m_halted) begin
      m_valid = 0;
    end else if (f) begin
      m_instr = 16'h0;
      m_valid = 0;
    end else if (s) begin
      if (m_cnt < 65535) m_cnt++;
    end else if (m_valid && m_instr[15:12] == 4'hF) begin
      m_halted = 1;
      m_valid  = 0;
    end else begin
      m_instr = i;
      m_pc    = p;
      m_valid = 1;
    end
    #1;
    check_regs();
  endtask

  initial begin
    rst = 1'b1; instr_in = 16'h0; pc_plus2_in = 16'h0; stall = 0; flush = 0;
    m_instr = 0; m_pc = 0; m_valid = 0; m_halted = 0; m_cnt = 0;

    pulse_reset();

    // Basic load
    step(16'h1234, 16'h0002, 0, 0);
    check("load_instr", {16'h0, instr_out}, 32'h1234);
    check("load_nop", {31'h0, nop_to_IDEX}, 32'h0);

    // Three stalled cycles with changing fetch data
    step(16'h5555, 16'h0004, 1, 0);
    step(16'h6666, 16'h0006, 1, 0);
    step(16'h7777, 16'h0008, 1, 0);
    check("stall_hold", {16'h0, instr_out}, 32'h1234);
`ifdef IFID_STALL_CNT_EN
    check("stall_cnt3", {16'h0, stall_cycles}, 32'h3);
`endif
    step(16'h2222, 16'h0004, 0, 0);

    // Flush beats simultaneous stall
    step(16'h3333, 16'h0006, 1, 1);
    check("flush_valid", {31'h0, valid_out}, 32'h0);

    // Halt held by a two-cycle stall, then committed
    step(16'hF000, 16'h0008, 0, 0);
    step(16'h4444, 16'h000A, 1, 0);
    step(16'h4444, 16'h000A, 1, 0);
    check("halt_wait", {31'h0, halted}, 32'h0);
    step(16'h4444, 16'h000A, 0, 0);
    step(16'h5555, 16'h000C, 0, 1);
    step(16'h6666, 16'h000E, 0, 0);
    check("halt_sticky", {31'h0, halted}, 32'h1);

    // Reset out of HALTED, then fetch resumes immediately
    pulse_reset();
    step(16'h0ABC, 16'h0010, 0, 0);
    check("resume_instr", {16'h0, instr_out}, 32'h0ABC);

    // Randomized traffic with occasional resets out of halt or mid-stall
    for (int n = 0; n < 400; n++) begin
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 63) == 0)
        pulse_reset();
      step(16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
